// File: rtl/exec_pkg.sv
// Shared definitions for the execute-stage multiply/divide unit: operation
// encodings, controller states and a width-generic most-negative constant.
package exec_pkg;

  typedef enum logic [1:0] {
    MULU = 2'b00,
    MUL  = 2'b01,
    DIVU = 2'b10,
    DIV  = 2'b11
  } opT;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX,
    DONE
  } stateT;

  // Widest operand the helper below can describe.
  localparam int unsigned MAX_WIDTH = 256;

  // Most-negative two's-complement value of the given width, right-aligned;
  // callers truncate to their own width.
  function automatic logic [MAX_WIDTH-1:0] mostNegative(input int unsigned width);
    return MAX_WIDTH'(1) << (width - 1);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the shared datapath: a shift/add multiply step or a
// restoring divide step on the 2*WIDTH accumulator. Purely combinational.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   operand,
  input  logic               isDiv,
  output logic [2*WIDTH-1:0] nextAcc,
  output logic               quoBit
);

  logic [WIDTH:0]   mulSum;
  logic [WIDTH:0]   remShift;
  logic [WIDTH+1:0] trial;

  // Multiply: conditional add into the upper half, then shift right with the
  // carry. Divide: shift {rem, quo} left, keep the trial difference if it
  // did not go negative. The quotient bit is returned separately and the
  // accumulator LSB is left clear for the caller to merge it in.
  always_comb begin
    // NOTE: every output gets a default first so no path can leave one
    // unassigned, which would infer a latch.
    nextAcc = '0;
    quoBit  = 1'b0;

    mulSum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
    remShift = acc[2*WIDTH-1:WIDTH-1];
    trial    = {1'b0, remShift} - {2'b00, operand};

    if (isDiv) begin
      quoBit  = ~trial[WIDTH+1];
      nextAcc = {(quoBit ? WIDTH'(trial) : remShift[WIDTH-1:0]), acc[WIDTH-2:0], 1'b0};
    end else begin
      nextAcc = {mulSum, acc[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/exec_muldiv.sv
// Iterative WIDTH-generic multiply/divide unit for the execute stage.
// Accept in IDLE, WIDTH iterations in RUN, sign fix-up and special cases in
// FIX, a one-cycle done pulse in DONE.
module exec_muldiv
  import exec_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic             stall_out,
  output logic [WIDTH-1:0] result_hi,
  output logic [WIDTH-1:0] result_lo,
  output logic             div_zero
);

  localparam int               CNT_W     = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MOST_NEG  = WIDTH'(mostNegative(WIDTH));

  stateT              state;
  opT                 opReg;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   operand;
  logic [WIDTH-1:0]   aMag;
  logic               resSign;
  logic               remSign;
  logic               bZero;
  logic               overflow;

  logic               isDivReg;
  logic               isSignedIn;
  logic               isDivIn;
  logic               aNegIn;
  logic               bNegIn;
  logic [WIDTH-1:0]   aMagIn;
  logic [WIDTH-1:0]   bMagIn;

  logic [2*WIDTH-1:0] stepAcc;
  logic               stepQuoBit;
  logic [2*WIDTH-1:0] prodFix;
  logic [WIDTH-1:0]   quoFix;
  logic [WIDTH-1:0]   remFix;

  assign isDivReg  = (opReg == DIVU) || (opReg == DIV);
  assign stall_out = start & ~done;

  // Operand magnitudes and signs as seen at the acceptance edge.
  always_comb begin
    isSignedIn = op[0];
    isDivIn    = op[1];
    aNegIn     = isSignedIn & a[WIDTH-1];
    bNegIn     = isSignedIn & b[WIDTH-1];
    aMagIn     = aNegIn ? -a : a;
    bMagIn     = bNegIn ? -b : b;
  end

  muldiv_step #(.WIDTH(WIDTH)) uStep (
    .acc     (acc),
    .operand (operand),
    .isDiv   (isDivReg),
    .nextAcc (stepAcc),
    .quoBit  (stepQuoBit)
  );

  // Sign correction and special cases applied to the finished iteration.
  // Remainder for b == 0 is the original dividend, rebuilt from its
  // magnitude and sign. The MIN / -1 case also falls out of the magnitude
  // arithmetic; it is pinned explicitly so the result never depends on it.
  always_comb begin
    prodFix = resSign ? -acc : acc;
    quoFix  = resSign ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    remFix  = remSign ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    if (bZero) begin
      quoFix = '1;
      remFix = remSign ? -aMag : aMag;
    end
    if (overflow) begin
      quoFix = MOST_NEG;
      remFix = '0;
    end
  end

  // Controller, iteration counter, operand registers and result registers.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  // NOTE: all state, datapath included, is cleared by reset so nothing ever
  // reads as X after power-up.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      opReg     <= MULU;
      cnt       <= '0;
      acc       <= '0;
      operand   <= '0;
      aMag      <= '0;
      resSign   <= 1'b0;
      remSign   <= 1'b0;
      bZero     <= 1'b0;
      overflow  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      result_hi <= '0;
      result_lo <= '0;
      div_zero  <= 1'b0;
    end else if (flush) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            opReg    <= opT'(op);
            aMag     <= aMagIn;
            operand  <= isDivIn ? bMagIn : aMagIn;
            acc      <= {{WIDTH{1'b0}}, (isDivIn ? aMagIn : bMagIn)};
            resSign  <= aNegIn ^ bNegIn;
            remSign  <= aNegIn;
            bZero    <= isDivIn && (b == '0);
            overflow <= (op == DIV) && (a == MOST_NEG) && (b == '1);
            cnt      <= '0;
            busy     <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          acc <= {stepAcc[2*WIDTH-1:1], stepAcc[0] | stepQuoBit};
          if (cnt == LAST_ITER) begin
            state <= FIX;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        FIX: begin
          if (isDivReg) begin
            result_hi <= remFix;
            result_lo <= quoFix;
            div_zero  <= bZero;
          end else begin
            {result_hi, result_lo} <= prodFix;
          end
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/exec_muldiv.md
# exec_muldiv

Parametrised iterative multiply/divide unit for the execute stage. Replaces the fixed 32-bit multiplier with a WIDTH-generic shift/add multiplier and restoring divider. Supports signed and unsigned operation, a pipeline-compatible stall output, a flush, and defined divide-by-zero and overflow results. Sits beside the ALU in execute; its double-width result feeds the FP register write bus exactly as the old multiplier result did.

## Interface
- WIDTH, 32, operand width in bits; must be at least 2.
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  operation request; held high by the pipeline until done.
- op  in  2  operation: 00 MULU, 01 MUL (signed), 10 DIVU, 11 DIV (signed).
- a  in  WIDTH  multiplicand or dividend.
- b  in  WIDTH  multiplier or divisor.
- flush  in  1  synchronous abort of any operation in flight.
- busy  out  1  high in RUN and FIX.
- done  out  1  one-cycle pulse; result_hi, result_lo and div_zero are valid that cycle.
- stall_out  out  1  combinational: start & ~done.
- result_hi  out  WIDTH  multiply: upper product half; divide: remainder.
- result_lo  out  WIDTH  multiply: lower product half; divide: quotient.
- div_zero  out  1  the last completed divide had b == 0.

## Operation
- States: IDLE, RUN, FIX, DONE.
- IDLE, start=1, flush=0: accept the operation.
  - Latch op.
  - Latch |a| and |b| for signed ops, raw values for unsigned ops.
  - Latch the result sign: a^b sign for the quotient and product, a sign for the remainder.
  - Clear the iteration counter; go to RUN.
- RUN runs for exactly WIDTH cycles.
  - Multiply: each cycle, if the accumulator LSB is 1, add the multiplicand to the upper half; shift the 2·WIDTH accumulator right by 1 with carry-in.
  - Divide: each cycle, shift {rem, quo} left by 1, trial-subtract the divisor from rem. If the result is non-negative, keep it and set the quotient LSB.
  - Counter reaches WIDTH−1 → go to FIX.
- FIX takes one cycle; it applies sign correction and the special cases.
  - Signed multiply: negate the 2·WIDTH product if the result sign is set.
  - Signed divide: negate the quotient if the quotient sign is set; negate the remainder if the dividend was negative. Division truncates toward zero.
  - b == 0 (DIV or DIVU): quotient = all ones, remainder = a as latched; div_zero = 1. Otherwise div_zero = 0 for divides; multiplies leave it unchanged.
  - DIV with a = most-negative and b = −1: quotient = most-negative, remainder = 0, no flag.
  - Write the result registers; go to DONE.
- DONE: done = 1 for this cycle only; return to IDLE unconditionally. A start still high in DONE is the consumed operation and is not re-accepted.
- Back-to-back operations: start high in the IDLE cycle after DONE is a new operation.
- flush=1 in any state:
  - next state IDLE, no done pulse;
  - result registers and div_zero keep their previous values;
  - flush has priority over start in IDLE.
- result_hi, result_lo and div_zero hold their values until the next FIX.
- reset low in any state, mid-operation included: asynchronous return to IDLE.
  - Reset values: busy 0, done 0, result_hi 0, result_lo 0, div_zero 0, counter 0.
  - stall_out then equals start.

## Timing
- Accepting edge = E0. RUN covers E1..E(WIDTH). FIX writes the results at E(WIDTH+1). done is high in the cycle after E(WIDTH+1).
- Latency from the accepting edge to done = WIDTH+2 cycles, identical for every op, divide-by-zero included.
- Throughput: one operation per WIDTH+3 cycles.
- stall_out is combinational with no register: high from the first cycle start is seen until the done cycle, low in the done cycle so the pipeline advances on that edge.
- The counter is ceil(log2(WIDTH)) bits and never wraps inside RUN.
- Operands are sampled only at acceptance; changes to a, b or op afterwards are ignored.

## Structure
- Shared package exec_pkg holds:
  - op encodings MULU/MUL/DIVU/DIV;
  - the state enum IDLE/RUN/FIX/DONE;
  - a function returning the most-negative WIDTH value.
- Sub-module muldiv_step: purely combinational single iteration. Inputs: accumulator, operand, mode. Outputs: next accumulator and quotient bit.
- The top level holds the FSM, counter, operand/sign registers, fix-up logic and result registers.

## Test plan
- MULU a=0xFFFFFFFF, b=0xFFFFFFFF → result_hi=0xFFFFFFFE, result_lo=0x00000001. done exactly 34 cycles after acceptance. stall_out high throughout except in the done cycle.
- MUL a=−3, b=7 → result_hi=0xFFFFFFFF, result_lo=0xFFFFFFEB. Then with start held through done, an immediate DIVU 100/7 → result_lo=14, result_hi=2.
- DIV a=−7, b=2 → result_lo=0xFFFFFFFD, result_hi=0xFFFFFFFF, div_zero=0.
- DIVU a=100, b=0 → result_lo=0xFFFFFFFF, result_hi=100, div_zero=1. DIV a=0x80000000, b=0xFFFFFFFF → result_lo=0x80000000, result_hi=0, div_zero=0.
- flush at RUN cycle 10 → busy low the next cycle, no done, previous results unchanged. A new start afterwards completes normally.
- reset low mid-RUN → all outputs at reset values immediately. After release, MULU 6×7 → result_lo=42, result_hi=0.
- Repeat all of the above with WIDTH=8, e.g. MUL −128×−1 → result_hi:result_lo = 0x0080, done 10 cycles after acceptance.
